// File: rtl/maxnet_arbiter.sv
// maxnet_arbiter: round-robin arbiter that lets four requesters share a single
// Maxnet engine. The winner's operands are latched and one start pulse is sent.
// The engine's result, or a timeout error, goes back to the winner with an ack.
module maxnet_arbiter #(
  parameter int TIMEOUT = 255  // 1..65535 WAIT cycles before abort
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [511:0] req_data,
  output logic [3:0]   gnt,
  output logic [3:0]   ack,
  output logic [31:0]  res_data,
  output logic         res_err,
  output logic         busy,
  output logic         mn_start,
  output logic [31:0]  mn_x1,
  output logic [31:0]  mn_x2,
  output logic [31:0]  mn_x3,
  output logic [31:0]  mn_x4,
  input  logic         mn_done,
  input  logic [31:0]  mn_result
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    owner_q;
  logic [15:0]   cnt_q;
  logic [3:0]    gnt_q;
  logic [3:0]    ack_q;
  logic [31:0]   res_data_q;
  logic          res_err_q;
  logic          busy_q;
  logic          mn_start_q;
  logic [127:0]  ops_q;

  logic          win_vld_d;
  logic [1:0]    win_idx_d;
  logic [1:0]    cand_d;
  logic [1:0]    ptr_d;
  logic [127:0]  ops_d;

  // Round-robin pick: first requester with req set, scanning from ptr upward.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = ptr_q;
    cand_d    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand_d = ptr_q + 2'(k);
      if (!win_vld_d && req[cand_d]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_d;
      end
    end
  end

  // Operand slice of the current round-robin candidate and the pointer after service.
  always_comb begin
    ops_d = req_data[{win_idx_d, 7'd0} +: 128];
    ptr_d = owner_q + 2'd1;
  end

  // Transaction FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      owner_q    <= 2'd0;
      cnt_q      <= 16'd0;
      gnt_q      <= 4'd0;
      ack_q      <= 4'd0;
      res_data_q <= 32'd0;
      res_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      mn_start_q <= 1'b0;
      ops_q      <= 128'd0;
    end else begin
      mn_start_q <= 1'b0;
      ack_q      <= 4'd0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q    <= LAUNCH;
            owner_q    <= win_idx_d;
            gnt_q      <= 4'b0001 << win_idx_d;
            busy_q     <= 1'b1;
            mn_start_q <= 1'b1;
            ops_q      <= ops_d;
          end
        end
        LAUNCH: begin
          // mn_done here belongs to nobody and is dropped.
          cnt_q   <= 16'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a timeout in the same cycle.
          if (mn_done) begin
            res_data_q <= mn_result;
            res_err_q  <= 1'b0;
            ack_q      <= gnt_q;
            state_q    <= RESP;
          end else if (cnt_q == TO_LAST) begin
            res_data_q <= 32'd0;
            res_err_q  <= 1'b1;
            ack_q      <= gnt_q;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          // Release the grant; owner's req state is irrelevant by now.
          state_q   <= IDLE;
          gnt_q     <= 4'd0;
          busy_q    <= 1'b0;
          res_err_q <= 1'b0;
          ptr_q     <= ptr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign res_data = res_data_q;
  assign res_err  = res_err_q;
  assign busy     = busy_q;
  assign mn_start = mn_start_q;
  assign mn_x1    = ops_q[31:0];
  assign mn_x2    = ops_q[63:32];
  assign mn_x3    = ops_q[95:64];
  assign mn_x4    = ops_q[127:96];

  // Grant and ack never name more than one requester.
  a_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q) && $onehot0(ack_q));

endmodule

// File: tb/tb_maxnet_arbiter.sv
// Randomized bench for maxnet_arbiter with a transaction-level reference model:
// the expected winner follows the round-robin rule, and ack/result timing follows
// from the engine delay chosen by the bench.
module tb_maxnet_arbiter;

  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [511:0] req_data;
  logic [3:0]   gnt, ack;
  logic [31:0]  res_data;
  logic         res_err, busy, mn_start;
  logic [31:0]  mn_x1, mn_x2, mn_x3, mn_x4;
  logic         mn_done;
  logic [31:0]  mn_result;

  int n_chk  = 0;
  int n_fail = 0;
  int m_ptr  = 0;

  maxnet_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .ack(ack), .res_data(res_data), .res_err(res_err),
    .busy(busy), .mn_start(mn_start),
    .mn_x1(mn_x1), .mn_x2(mn_x2), .mn_x3(mn_x3), .mn_x4(mn_x4),
    .mn_done(mn_done), .mn_result(mn_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester scanned first from m_ptr upward that has its bit set.
  function automatic int winner(input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [127:0] ops_now();
    return {mn_x4, mn_x3, mn_x2, mn_x1};
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 16; i++) req_data[i*32 +: 32] = $urandom();
  endtask

  // Idle cycles with no request, optionally with stray engine completions.
  task automatic idle(input int n, input bit spur);
    req = 4'd0;
    for (int i = 0; i < n; i++) begin
      mn_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk("idle_busy", 128'(busy), 128'(0));
      chk("idle_gnt", 128'(gnt), 128'(0));
      chk("idle_ack", 128'(ack), 128'(0));
      chk("idle_start", 128'(mn_start), 128'(0));
    end
    mn_done = 1'b0;
  endtask

  // One full transaction. Called at a negedge while the DUT sits in IDLE.
  // d = WAIT cycle in which the engine reports done; d > TO means it never does.
  task automatic run_txn(input logic [3:0] r, input int d, input logic [31:0] res,
                         input bit drop, input bit spur);
    int w;
    int lim;
    logic [127:0] ops;
    logic [127:0] one_w;
    w     = winner(r);
    req   = r;
    ops   = req_data[w*128 +: 128];
    one_w = 128'(1) << w;
    @(negedge clk);
    chk("launch_gnt", 128'(gnt), one_w);
    chk("launch_start", 128'(mn_start), 128'(1));
    chk("launch_busy", 128'(busy), 128'(1));
    chk("launch_ops", ops_now(), ops);
    chk("launch_ack", 128'(ack), 128'(0));
    rand_data();
    if (drop) req[w] = 1'b0;
    mn_done   = spur;
    mn_result = $urandom();
    lim = (d <= TO) ? d : TO;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      mn_done = 1'b0;
      chk("wait_start", 128'(mn_start), 128'(0));
      chk("wait_ack", 128'(ack), 128'(0));
      chk("wait_gnt", 128'(gnt), one_w);
      chk("wait_ops", ops_now(), ops);
      if (k == d) begin
        mn_done   = 1'b1;
        mn_result = res;
      end
    end
    @(negedge clk);
    mn_done = 1'b0;
    chk("resp_ack", 128'(ack), one_w);
    chk("resp_data", 128'(res_data), (d <= TO) ? 128'(res) : 128'(0));
    chk("resp_err", 128'(res_err), (d <= TO) ? 128'(0) : 128'(1));
    chk("resp_gnt", 128'(gnt), one_w);
    chk("resp_start", 128'(mn_start), 128'(0));
    @(negedge clk);
    chk("post_ack", 128'(ack), 128'(0));
    chk("post_gnt", 128'(gnt), 128'(0));
    chk("post_busy", 128'(busy), 128'(0));
    chk("post_start", 128'(mn_start), 128'(0));
    m_ptr = (w + 1) % 4;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; req = 4'd0; req_data = '0; mn_done = 1'b0; mn_result = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 128'(gnt), 128'(0));
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_start", 128'(mn_start), 128'(0));
    chk("rst_res", 128'({res_err, res_data}), 128'(0));
    chk("rst_ops", ops_now(), 128'(0));
    rst = 1'b0;
    m_ptr = 0;

    // All four requesting continuously: grants 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      rand_data();
      run_txn(4'hF, 4, $urandom(), 1'b0, 1'b0);
    end

    // Single requester, operands (5,9,3,7), result 9 after 6 cycles.
    idle(1, 1'b1);
    req_data[127:0] = {32'd7, 32'd3, 32'd9, 32'd5};
    run_txn(4'b0001, 6, 32'd9, 1'b0, 1'b0);

    // Requester 2 served, then 0101 picks 0 before 2.
    run_txn(4'b0100, 2, $urandom(), 1'b0, 1'b0);
    run_txn(4'b0101, 3, $urandom(), 1'b0, 1'b0);
    run_txn(4'b0101, 1, $urandom(), 1'b0, 1'b0);

    // Timeout, then done exactly on the timeout cycle, then a normal transaction.
    run_txn(4'b0010, 1000, $urandom(), 1'b0, 1'b0);
    run_txn(4'b0010, TO, 32'h1234_5678, 1'b0, 1'b0);
    run_txn(4'b0010, 3, 32'hA5A5_0001, 1'b0, 1'b0);

    // Spurious done while idle, owner drops req during WAIT.
    idle(3, 1'b1);
    run_txn(4'b0001, 5, 32'hCAFE_0005, 1'b1, 1'b1);

    // Reset in the middle of WAIT, late done ignored, fresh grant for 1000.
    rand_data();
    req = 4'b0110;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 128'(gnt), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_res", 128'({res_err, res_data}), 128'(0));
    chk("mid_rst_ops", ops_now(), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    req = 4'd0;
    mn_done = 1'b1;
    mn_result = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_done_ack", 128'(ack), 128'(0));
    chk("late_done_busy", 128'(busy), 128'(0));
    chk("late_done_res", 128'(res_data), 128'(0));
    mn_done = 1'b0;
    rand_data();
    run_txn(4'b1000, 2, $urandom(), 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), 1'b1);
      rand_data();
      w = $urandom_range(1, 15);
      run_txn(4'(w), $urandom_range(1, TO + 3), $urandom(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
